// File: rtl/serial_twos_pkg.sv
// Shared types and defaults for the serial two's-complement negator.
package serial_twos_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_twos_bit.sv
// Bit-serial Mealy core: pass bits through until the first 1 has been seen,
// then invert every later bit.
module serial_twos_bit (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic b,
  output logic r,
  output logic seen_one
);

  logic r_seen_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (en) begin
      r_seen_one <= r_seen_one | b;
    end
  end

  assign r        = r_seen_one ^ b;
  assign seen_one = r_seen_one;

endmodule

// File: rtl/serial_twos_negator.sv
// Word-level negator: accepts an operand, negates it LSB first through the
// bit-serial core, then presents the result under valid/ready.
module serial_twos_negator
  import serial_twos_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             ovf,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_msb;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;
  logic             w_r;
  logic             w_seen_one;

  assign w_accept = (r_state == IDLE) & in_valid;
  assign w_shift  = (r_state == SHIFT);
  assign w_last   = w_shift & (r_cnt == CNT_W'(WIDTH - 1));

  serial_twos_bit u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_accept),
    .en       (w_shift),
    .b        (r_sreg[0]),
    .r        (w_r),
    .seen_one (w_seen_one)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result enters MSB-side so that after WIDTH shifts bit 0 lands at dout[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_in_msb <= 1'b0;
    end else if (w_accept) begin
      r_sreg   <= din;
      r_cnt    <= '0;
      r_in_msb <= din[WIDTH-1];
    end else if (w_shift) begin
      r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
      r_res  <= {w_r, r_res[WIDTH-1:1]};
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign dout      = r_res;
  assign ovf       = out_valid & r_in_msb & r_res[WIDTH-1];
  assign zero      = out_valid & ~w_seen_one;

endmodule

// File: doc/serial_twos_negator.md
Name: serial_twos_negator

Overview:
- Word-level two's-complement negator built around a bit-serial Mealy core (copy bits up to and including the first 1, invert all later bits).
- Sits directly upstream of the twos_comple_fsm detector stage and feeds it negated words through a valid/ready handshake.
- Processes one bit per clock, LSB first, so throughput is one word per WIDTH+2 cycles.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  din holds a valid operand.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- din  input  WIDTH  operand, two's complement.
- out_valid  output  1  dout, ovf and zero are valid; high only in DONE.
- out_ready  input  1  downstream accepts the result.
- dout  output  WIDTH  negated operand, i.e. -din mod 2^WIDTH.
- ovf  output  1  operand was the most negative value (1 followed by WIDTH-1 zeros), so the result is not representable.
- zero  output  1  operand was 0.

Behaviour:
- Reset (reset=0, asynchronous) sets all registers immediately:
  - state=IDLE; in_ready=1; out_valid=0; dout=0; ovf=0; zero=0.
  - The internal shift register, counter and seen_one are cleared.
- Deassertion of reset is taken synchronously at the next clk edge.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load the shift register with din, capture din[WIDTH-1] as in_msb, clear cnt and seen_one, and go to SHIFT.
  - Otherwise stay in IDLE.
- State SHIFT (in_ready=0, out_valid=0):
  - Each edge consumes bit b = sreg[0].
  - Result bit r = seen_one ? ~b : b, written into the result register MSB-side; the result register shifts right.
  - Update seen_one |= b and cnt += 1.
  - When cnt reaches WIDTH-1 on that edge, go to DONE.
  - SHIFT therefore lasts exactly WIDTH edges.
- State DONE:
  - out_valid=1; dout holds the result.
  - ovf = in_msb & dout[WIDTH-1].
  - zero = ~seen_one.
  - On an edge with out_ready=1, go to IDLE. out_valid falls and in_ready rises after that edge.
  - While out_ready=0, dout, ovf and zero stay stable (backpressure hold).
- Latency: acceptance at edge e0 gives out_valid=1 after edge e0+WIDTH. The earliest next acceptance is at edge e0+WIDTH+2.
- in_valid is ignored outside IDLE. din is sampled only at the acceptance edge; later changes to din have no effect.
- No combinational path from in_valid or out_ready to in_ready or out_valid. All outputs are registered or decoded from state only.
- Reset asserted mid-SHIFT or in DONE aborts the word. No partial result is emitted, and out_valid drops immediately (asynchronous).
- Boundary cases:
  - Input 0: dout=0, zero=1, ovf=0.
  - Most negative input: dout equals din, ovf=1.
  - Input 1: dout is all ones.
  - Upper bound: cnt never exceeds WIDTH-1.

Decomposition:
- Package serial_twos_pkg holds:
  - State enum {IDLE=2'b00, SHIFT=2'b01, DONE=2'b10}. The illegal code 2'b11 recovers to IDLE.
  - Default WIDTH constant.
- One sub-module, serial_twos_bit: the 1-bit Mealy core.
  - Inputs: clk, reset, clr, en, b.
  - Outputs: r (combinational from b and seen_one), seen_one.
  - The top level holds the handshake FSM, counter and shift registers.

Test Plan:
- WIDTH=4, din=0010, out_ready=1 → out_valid rises 4 edges after acceptance; dout=1110, ovf=0, zero=0.
- din=1111 then din=1011 back-to-back, in_valid held high → dout=0001, then dout=0101; second acceptance occurs exactly WIDTH+2 edges after the first.
- din=0000 → dout=0000, zero=1, ovf=0. Then din=1000 → dout=1000, ovf=1, zero=0.
- din=1001, out_ready=0 for 3 cycles after out_valid rises → dout stays 0111 and in_ready stays 0; a toggling din during the hold has no effect; IDLE one edge after out_ready=1.
- Assert reset=0 asynchronously two edges into SHIFT → out_valid=0 and in_ready=1 immediately, dout=0; a fresh din=0010 after release gives 1110.
- Randomised sweep of all 16 values for WIDTH=4 plus 1000 random values for WIDTH=8 with random out_ready → dout equals (~din+1) mod 2^WIDTH for every word, with zero and ovf matching the reference model.
